// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared types and constants for the multiply/divide unit.
// Holds the FSM state enum, the default operand width, the iteration count,
// the iteration counter width and a two's-complement magnitude helper.
// The DIV state exists only when MULTDIV_DIV_EN is defined.
package multdiv_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int ITERS = 32;
  localparam int CNT_W = 6;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
`ifdef MULTDIV_DIV_EN
    DIV  = 2'd2,
`endif
    DONE = 2'd3
  } stateT;
  function automatic logic [WIDTH_DEF-1:0] absVal(input logic [WIDTH_DEF-1:0] v);
    return v[WIDTH_DEF-1] ? -v : v;
  endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
// Ports: rem (partial remainder, always < divisor), inBit (next dividend bit),
//        divisor (magnitude), nextRem (updated remainder), qBit (quotient bit).
module div_step
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             inBit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] nextRem,
  output logic             qBit
);
  logic [WIDTH:0] shifted;
  assign shifted = {rem, inBit};
  assign qBit = shifted >= {1'b0, divisor};
  // shifted < 2*divisor, so the subtracted value always fits back into WIDTH bits
  assign nextRem = WIDTH'(qBit ? shifted - {1'b0, divisor} : shifted);
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed multiply (radix-2 Booth) and signed divide (restoring).
// Ports: clk, reset (async, active-low), a/b operands, multControl/divControl start
//        pulses, hi/lo results, busy, done (one-cycle), divZero (one-cycle).
// Macro MULTDIV_DIV_EN compiles in the divider; without it divControl is ignored.
// Timing: start sampled in IDLE, one set-up cycle, 32 iterations, results land on
// the 33rd edge after the start edge, then one DONE cycle.
module mult_div_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             multControl,
  input  logic             divControl,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             divZero
);
  stateT state, nextState;
  logic [CNT_W-1:0] cnt;
  logic init, qm1, lastIter, divStart;
  logic [WIDTH-1:0] opA, opB, low, divInit;
  logic [WIDTH:0] acc, boothSum;
  logic [2*WIDTH+1:0] divNext;
  logic [2*WIDTH-1:0] divRes;

  assign busy = state != IDLE && state != DONE;
  assign done = state == DONE;
  assign lastIter = busy && !init && cnt == CNT_W'(ITERS - 1);
  // accumulator carries one guard bit so -2^31 as multiplicand cannot overflow
  assign boothSum = low[0] && !qm1 ? acc - {opA[WIDTH-1], opA} :
                    !low[0] && qm1 ? acc + {opA[WIDTH-1], opA} : acc;

`ifdef MULTDIV_DIV_EN
  logic [WIDTH-1:0] stepRem, quot;
  logic stepQ;
  div_step #(.WIDTH(WIDTH)) step (
    .rem(acc[WIDTH-1:0]),
    .inBit(low[WIDTH-1]),
    .divisor(absVal(opB)),
    .nextRem(stepRem),
    .qBit(stepQ)
  );
  assign quot = {low[WIDTH-2:0], stepQ};
  assign divStart = divControl && b != '0;
  assign divInit = absVal(opA);
  assign divNext = {1'b0, stepRem, quot, 1'b0};
  // sign fix-up: quotient truncates toward zero, remainder follows the dividend
  assign divRes = {opA[WIDTH-1] ? -stepRem : stepRem,
                   opA[WIDTH-1] ^ opB[WIDTH-1] ? -quot : quot};
  always_ff @(posedge clk or negedge reset)
    if (!reset) divZero <= 1'b0;
    else divZero <= state == IDLE && !multControl && divControl && b == '0;
`else
  logic unusedDivControl;
  assign unusedDivControl = divControl;
  assign divStart = 1'b0;
  assign divInit = '0;
  assign divNext = '0;
  assign divRes = '0;
  assign divZero = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nextState;

  always_comb begin
    nextState = state;
    if (state == IDLE && multControl) nextState = MULT;
`ifdef MULTDIV_DIV_EN
    else if (state == IDLE && divStart) nextState = DIV;
`endif
    else if (state == DONE) nextState = IDLE;
    else if (lastIter) nextState = DONE;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      init <= 1'b0;
      opA <= '0;
      opB <= '0;
      acc <= '0;
      low <= '0;
      qm1 <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else if (state == IDLE) begin
      if (multControl || divStart) begin
        opA <= a;
        opB <= b;
        init <= 1'b1;
        cnt <= '0;
      end
    end else if (init) begin
      acc <= '0;
      low <= state == MULT ? opB : divInit;
      qm1 <= 1'b0;
      init <= 1'b0;
    end else if (busy) begin
      cnt <= cnt + 1'b1;
      // Booth: arithmetic right shift of {acc, low, qm1} after the add/subtract
      {acc, low, qm1} <= state == MULT ? {boothSum[WIDTH], boothSum, low} : divNext;
      if (lastIter) {hi, lo} <= state == MULT ? {boothSum, low[WIDTH-1:1]} : divRes;
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit with a plain-arithmetic reference.
module tb_mult_div_unit;
`ifdef MULTDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, multControl = 1'b0, divControl = 1'b0;
  logic [31:0] a = '0, b = '0, hi, lo;
  logic busy, done, divZero;

  mult_div_unit dut (
    .clk(clk),
    .reset(reset),
    .a(a),
    .b(b),
    .multControl(multControl),
    .divControl(divControl),
    .hi(hi),
    .lo(lo),
    .busy(busy),
    .done(done),
    .divZero(divZero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic dz;
    logic [31:0] hi;
    logic [31:0] lo;
    int cyc;
  } expT;
  expT q[$];
  int cyc = 0, checks = 0, fails = 0;
  logic [31:0] mHi = '0, mLo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference: 64-bit signed arithmetic; sc is the cycle number of the sampling edge
  function automatic void model(input bit isDiv, input logic [31:0] x, input logic [31:0] y, input int sc);
    expT e;
    longint sx, sy, p, qt, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!isDiv) begin
      p = sx * sy;
      e.dz = 1'b0; e.hi = p[63:32]; e.lo = p[31:0]; e.cyc = sc + 33;
    end else if (!DIV_EN) begin
      return;
    end else if (y == 0) begin
      e.dz = 1'b1; e.hi = mHi; e.lo = mLo; e.cyc = sc;
    end else begin
      qt = sx / sy;
      r = sx - qt * sy;
      e.dz = 1'b0; e.hi = r[31:0]; e.lo = qt[31:0]; e.cyc = sc + 33;
    end
    mHi = e.hi;
    mLo = e.lo;
    q.push_back(e);
  endfunction

  // issues one start and returns at the negedge of the expected done cycle
  task automatic doOp(input bit isDiv, input logic [31:0] x, input logic [31:0] y,
                      input bit both = 1'b0, input bit intrude = 1'b0);
    bit accepted;
    @(negedge clk);
    a = x;
    b = y;
    multControl = !isDiv || both;
    divControl = isDiv || both;
    accepted = !isDiv || both || (DIV_EN && y != 0);
    model(isDiv && !both, x, y, cyc + 1);
    @(negedge clk);
    multControl = 1'b0;
    divControl = 1'b0;
    a = $urandom;
    b = $urandom;
    check("busy_after_start", {63'b0, busy}, {63'b0, accepted});
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      multControl = intrude && i == 4;
      if (multControl) begin
        a = $urandom;
        b = $urandom;
      end
    end
    multControl = 1'b0;
    check("hold_hi", {32'b0, hi}, {32'b0, mHi});
    check("hold_lo", {32'b0, lo}, {32'b0, mLo});
  endtask

  always @(negedge clk) begin
    expT e;
    if (q.size() > 0 && cyc > q[0].cyc) begin
      check("late_response", 64'(cyc), 64'(q[0].cyc));
      void'(q.pop_front());
    end
    if (done || divZero) begin
      if (q.size() == 0) check("unexpected_output", {62'b0, done, divZero}, 64'b0);
      else begin
        e = q.pop_front();
        check("kind_divzero", {63'b0, divZero}, {63'b0, e.dz});
        check("latency", 64'(cyc), 64'(e.cyc));
        check("hi", {32'b0, hi}, {32'b0, e.hi});
        check("lo", {32'b0, lo}, {32'b0, e.lo});
        check("busy_at_output", {63'b0, busy}, 64'b0);
      end
    end
  end

  initial begin
    logic [31:0] x, y;
    bit isDiv;
    repeat (2) @(negedge clk);
    check("reset_hi", {32'b0, hi}, 64'b0);
    check("reset_lo", {32'b0, lo}, 64'b0);
    check("reset_busy", {63'b0, busy}, 64'b0);
    check("reset_done", {63'b0, done}, 64'b0);
    check("reset_divzero", {63'b0, divZero}, 64'b0);
    reset = 1'b1;
    doOp(1'b0, 32'd7, 32'hFFFFFFFD);
    doOp(1'b0, 32'h80000000, 32'h80000000);
    doOp(1'b1, 32'hFFFFFFF9, 32'd2);
    doOp(1'b1, 32'h80000000, 32'hFFFFFFFF);
    doOp(1'b0, 32'hDB975310, 32'h80000000);
    doOp(1'b1, 32'd5, 32'd0);
    doOp(1'b0, 32'd100, 32'd7, 1'b1);
    doOp(1'b0, 32'hCAFEF00D, 32'h12345678, 1'b0, 1'b1);
    multControl = 1'b1;
    a = 32'h0BADBEEF;
    b = 32'h00C0FFEE;
    doOp(1'b0, 32'hFFFF0001, 32'h7FFFFFFF);
    @(negedge clk);
    a = 32'h00001234;
    b = 32'h00005678;
    multControl = 1'b1;
    model(1'b0, a, b, cyc + 1);
    @(negedge clk);
    multControl = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    q.delete();
    mHi = '0;
    mLo = '0;
    check("abort_hi", {32'b0, hi}, 64'b0);
    check("abort_lo", {32'b0, lo}, 64'b0);
    check("abort_busy", {63'b0, busy}, 64'b0);
    check("abort_done", {63'b0, done}, 64'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    doOp(1'b0, 32'h00001234, 32'h00005678);
    for (int i = 0; i < 24; i++) begin
      isDiv = DIV_EN ? 1'($urandom % 2) : ($urandom % 4 == 0);
      x = ($urandom % 8 == 0) ? 32'h80000000 : $urandom;
      y = ($urandom % 6 == 0) ? 32'h0 : ($urandom % 6 == 0) ? 32'hFFFFFFFF : $urandom;
      if (!isDiv && y == 0) y = 32'h00000003;
      doOp(isDiv, x, y);
    end
    repeat (3) @(negedge clk);
    if (q.size() != 0) check("scoreboard_drained", 64'(q.size()), 64'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
